div_result_reconstructor: RTL and testbench

//  Consumer-side checker for the 2W/W array dividers: takes {n, d, q, r} and rebuilds
//  n_hat = q*d + r with a sequential shift-add multiplier.

---
 rtl/div_result_reconstructor.sv | 199 +++++++++++++++++++
 tb/tb_div_result_reconstructor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_reconstructor.sv
// Rebuilds n_hat = q*d + r with a fixed-latency shift-add multiplier and reports err = n - n_hat.
// Optional statistics (sum of err^2, sample count) are enabled by defining DIV_ERR_STATS_EN.
module div_result_reconstructor #(
  parameter int W     = 8,
  parameter int ACC_W = 48,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   n,
  input  logic [W-1:0]     d,
  input  logic [W-1:0]     q,
  input  logic [W-1:0]     r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   n_hat,
  output logic [2*W:0]     err,
  output logic             div_zero,
  output logic             exact
`ifdef DIV_ERR_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [ACC_W-1:0] sq_err_acc,
  output logic [CNT_W-1:0] sample_cnt
`endif
);

  localparam int CNT_BW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [2*W-1:0]      n_r;
  logic [2*W-1:0]      acc_r;
  logic [2*W-1:0]      mcand_r;
  logic [W-1:0]        mplier_r;
  logic [CNT_BW-1:0]   cnt_r;
  logic                d_zero_r;
  logic [2*W-1:0]      n_hat_r;
  logic [2*W:0]        err_r;
  logic                div_zero_r;
  logic                exact_r;

  logic                accept_s;
  logic                last_s;
  logic                hs_s;
  logic [2*W-1:0]      acc_add_s;
  logic [2*W:0]        err_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign accept_s  = in_valid && (state_r == IDLE);
  assign hs_s      = out_ready && (state_r == DONE);
  assign last_s    = (cnt_r == CNT_BW'(W - 1));
  assign n_hat     = n_hat_r;
  assign err       = err_r;
  assign div_zero  = div_zero_r;
  assign exact     = exact_r;

  // Partial-product add for the current multiplier bit and the resulting error
  always_comb begin
    acc_add_s = acc_r;
    if (mplier_r[0]) begin
      acc_add_s = acc_r + mcand_r;
    end else begin
      acc_add_s = acc_r;
    end
    err_s = {1'b0, n_r} - {1'b0, acc_add_s};
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = MUL;
        else          state_nxt_s = IDLE;
      end
      MUL: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = MUL;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Operand capture, shift-add iteration and result registers (results update only on the last MUL edge)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r        <= {(2*W){1'b0}};
      acc_r      <= {(2*W){1'b0}};
      mcand_r    <= {(2*W){1'b0}};
      mplier_r   <= {W{1'b0}};
      cnt_r      <= {CNT_BW{1'b0}};
      d_zero_r   <= 1'b0;
      n_hat_r    <= {(2*W){1'b0}};
      err_r      <= {(2*W+1){1'b0}};
      div_zero_r <= 1'b0;
      exact_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            n_r      <= n;
            acc_r    <= {{W{1'b0}}, r};
            mcand_r  <= {{W{1'b0}}, d};
            mplier_r <= q;
            cnt_r    <= {CNT_BW{1'b0}};
            d_zero_r <= (d == {W{1'b0}});
          end
        end
        MUL: begin
          acc_r    <= acc_add_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_BW'(1);
          if (last_s) begin
            n_hat_r    <= acc_add_s;
            err_r      <= err_s;
            div_zero_r <= d_zero_r;
            exact_r    <= (err_s == {(2*W+1){1'b0}});
          end
        end
        DONE: begin
          n_hat_r <= n_hat_r;
        end
        default: begin
          n_hat_r <= n_hat_r;
        end
      endcase
    end
  end

`ifdef DIV_ERR_STATS_EN
  localparam int SQ_W  = 4*W + 2;
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

  function automatic logic [ACC_W-1:0] sat_add_acc(input logic [ACC_W-1:0] a,
                                                   input logic [SQ_W-1:0]  b);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] lim;
    sum = SUM_W'(a) + SUM_W'(b);
    lim = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
    if (sum > lim) sat_add_acc = {ACC_W{1'b1}};
    else           sat_add_acc = sum[ACC_W-1:0];
  endfunction

  logic [ACC_W-1:0] sq_err_acc_r;
  logic [CNT_W-1:0] sample_cnt_r;
  logic [2*W:0]     mag_s;
  logic [SQ_W-1:0]  sq_s;

  assign sq_err_acc = sq_err_acc_r;
  assign sample_cnt = sample_cnt_r;

  // Magnitude of the signed error, squared
  always_comb begin
    mag_s = err_r;
    if (err_r[2*W]) mag_s = -err_r;
    else            mag_s = err_r;
    sq_s = SQ_W'(mag_s) * SQ_W'(mag_s);
  end

  // Saturating statistics; a clear takes priority over a coincident handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_err_acc_r <= {ACC_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
    end else if (stats_clr) begin
      sq_err_acc_r <= {ACC_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
    end else if (hs_s) begin
      sq_err_acc_r <= sat_add_acc(sq_err_acc_r, sq_s);
      if (sample_cnt_r != {CNT_W{1'b1}}) sample_cnt_r <= sample_cnt_r + CNT_W'(1);
    end
  end
`else
  logic unused_hs_s;
  assign unused_hs_s = hs_s;
`endif

endmodule

// File: tb/tb_div_result_reconstructor.sv
// Directed, table-driven bench for div_result_reconstructor (W=8) with hand-written
// sequences for backpressure, mid-operation reset and, when enabled, statistics.
module tb_div_result_reconstructor;

  localparam int W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   n;
  logic [W-1:0]     d;
  logic [W-1:0]     q;
  logic [W-1:0]     r;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   n_hat;
  logic [2*W:0]     err;
  logic             div_zero;
  logic             exact;
`ifdef DIV_ERR_STATS_EN
  logic             stats_clr;
  logic [47:0]      sq_err_acc;
  logic [31:0]      sample_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  r;
    logic [15:0] exp_n_hat;
    logic [16:0] exp_err;
    logic        exp_dz;
    logic        exp_exact;
  } vec_t;

  vec_t vecs [8];

  div_result_reconstructor #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_hat     (n_hat),
    .err       (err),
    .div_zero  (div_zero),
    .exact     (exact)
`ifdef DIV_ERR_STATS_EN
    ,
    .stats_clr (stats_clr),
    .sq_err_acc(sq_err_acc),
    .sample_cnt(sample_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one sample into IDLE and take the accept edge
  task automatic accept(input vec_t v);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("ready_before_accept", 64'(in_ready), 64'd1);
    @(negedge clk);
    n = v.n; d = v.d; q = v.q; r = v.r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", 64'(in_ready), 64'd0);
    check("busy_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic wait_done();
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'd8);
  endtask

  task automatic check_out(input vec_t v);
    check("out_valid", 64'(out_valid), 64'd1);
    check("n_hat",     64'(n_hat),     64'(v.exp_n_hat));
    check("err",       64'(err),       64'(v.exp_err));
    check("div_zero",  64'(div_zero),  64'(v.exp_dz));
    check("exact",     64'(exact),     64'(v.exp_exact));
    check("done_in_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_in_ready",  64'(in_ready),  64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic run(input vec_t v);
    accept(v);
    wait_done();
    check_out(v);
    handshake();
  endtask

  initial begin
    vec_t bp;
    vec_t other;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n = 16'd0; d = 8'd0; q = 8'd0; r = 8'd0;
`ifdef DIV_ERR_STATS_EN
    stats_clr = 1'b0;
`endif

    vecs[0] = '{16'd1000,  8'd7,   8'd142, 8'd6,   16'd1000,  17'd0,       1'b0, 1'b1};
    vecs[1] = '{16'd1000,  8'd7,   8'd140, 8'd3,   16'd983,   17'd17,      1'b0, 1'b0};
    vecs[2] = '{16'd0,     8'd255, 8'd255, 8'd254, 16'd65279, 17'h10101,   1'b0, 1'b0};
    vecs[3] = '{16'd100,   8'd0,   8'd255, 8'd5,   16'd5,     17'd95,      1'b1, 1'b0};
    vecs[4] = '{16'd5,     8'd3,   8'd1,   8'd0,   16'd3,     17'd2,       1'b0, 1'b0};
    vecs[5] = '{16'd0,     8'd0,   8'd0,   8'd0,   16'd0,     17'd0,       1'b1, 1'b1};
    vecs[6] = '{16'd65535, 8'd255, 8'd255, 8'd255, 16'd65280, 17'd255,     1'b0, 1'b0};
    vecs[7] = '{16'd10,    8'd2,   8'd9,   8'd3,   16'd21,    17'h1FFF5,   1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_n_hat",     64'(n_hat),     64'd0);
    check("rst_err",       64'(err),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run(vecs[i]);
    end

    // Backpressure: result held for 5 cycles while a competing input is ignored
    bp    = vecs[1];
    other = vecs[6];
    accept(bp);
    wait_done();
    @(negedge clk);
    n = other.n; d = other.d; q = other.q; r = other.r;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_out(bp);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_in_ready",  64'(in_ready),  64'd1);
    check("bp_idle_out_valid", 64'(out_valid), 64'd0);
    check("bp_n_hat_held",     64'(n_hat),     64'(bp.exp_n_hat));

    // Asynchronous reset three cycles into the multiply
    accept(vecs[6]);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_n_hat",     64'(n_hat),     64'd0);
    check("mid_rst_err",       64'(err),       64'd0);
    check("mid_rst_div_zero",  64'(div_zero),  64'd0);
    check("mid_rst_exact",     64'(exact),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(vecs[2]);

`ifdef DIV_ERR_STATS_EN
    begin
      vec_t neg3;
      neg3 = '{16'd10, 8'd2, 8'd5, 8'd3, 16'd13, 17'h1FFFD, 1'b0, 1'b0};
      @(negedge clk);
      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      check("stats_clr_acc", 64'(sq_err_acc), 64'd0);
      check("stats_clr_cnt", 64'(sample_cnt), 64'd0);
      run(vecs[1]);
      run(neg3);
      check("stats_acc", 64'(sq_err_acc), 64'd298);
      check("stats_cnt", 64'(sample_cnt), 64'd2);
      accept(vecs[4]);
      wait_done();
      check_out(vecs[4]);
      stats_clr = 1'b1;
      handshake();
      stats_clr = 1'b0;
      check("stats_coinc_acc", 64'(sq_err_acc), 64'd0);
      check("stats_coinc_cnt", 64'(sample_cnt), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
